// File: rtl/sdadc_pkg.sv
// Shared constants and helpers for the sigma-delta ADC decimation chain.
package sdadc_pkg;

    // Modulator bit to sample mapping: 1 -> +1, 0 -> -1
    localparam int CIC_PLUS_ONE  = 1;
    localparam int CIC_MINUS_ONE = -1;

    // Register growth of an N-stage CIC: 2 + N*log2(R*M)
    function automatic int unsigned cic_acc_width(input int unsigned order,
                                                  input int unsigned rate,
                                                  input int unsigned delay);
        return 32'(2 + order * 32'($clog2(rate * delay)));
    endfunction

    function automatic longint sat_max(input int unsigned width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/cic_comb.sv
// One CIC comb stage: diff_c = x - x delayed DIFF_DELAY strobes; delay line advances on en.
module cic_comb #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIFF_DELAY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] diff_c
);

    logic signed [WIDTH-1:0] dly [DIFF_DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DIFF_DELAY); i++) dly[i] <= '0;
        end else if (en) begin
            dly[0] <= x;
            for (int i = 1; i < int'(DIFF_DELAY); i++) dly[i] <= dly[i-1];
        end
    end

    assign diff_c = x - dly[DIFF_DELAY-1];

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator for a 1-bit sigma-delta stream: pipelined integrators, strobed combs, scale + saturate.
// Build option: define CIC_ROUND_EN for round-half-up before the output shift (default truncates).
module cic_decimator
    import sdadc_pkg::*;
#(
    parameter int unsigned CIC_ORDER  = 5,
    parameter int unsigned DEC_RATE   = 64,
    parameter int unsigned DIFF_DELAY = 1,
    parameter int unsigned OUT_WIDTH  = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        data_in,
    input  logic                        in_valid,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        out_valid
);

    localparam int unsigned ACC_WIDTH = cic_acc_width(CIC_ORDER, DEC_RATE, DIFF_DELAY);
    localparam int unsigned SHIFT     = ACC_WIDTH - OUT_WIDTH;
    localparam int unsigned CNT_WIDTH = 32'($clog2(DEC_RATE));

    localparam logic [CNT_WIDTH-1:0]     CNT_LAST = CNT_WIDTH'(DEC_RATE - 1);
    localparam logic signed [OUT_WIDTH:0] SAT_HI  = (OUT_WIDTH+1)'(sat_max(OUT_WIDTH));
    localparam logic signed [OUT_WIDTH:0] SAT_LO  = (OUT_WIDTH+1)'(sat_min(OUT_WIDTH));
`ifdef CIC_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS = (ACC_WIDTH+1)'(1) << (SHIFT - 1);
`else
    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS = '0;
`endif

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    acc_t                  integ [CIC_ORDER];
    acc_t                  step;
    logic [CNT_WIDTH-1:0]  dec_cnt;
    logic                  dec_strobe;
    logic                  samp_vld;
    acc_t                  samp;
    acc_t                  comb [CIC_ORDER+1];
    logic signed [ACC_WIDTH:0] biased;
    logic signed [ACC_WIDTH:0] shifted_full;
    logic signed [OUT_WIDTH:0] shifted;
    logic signed [OUT_WIDTH-1:0] scaled;

    assign step = data_in ? ACC_WIDTH'(CIC_PLUS_ONE) : ACC_WIDTH'(CIC_MINUS_ONE);

    // Each stage adds the previous stage's registered value, so stage k lags by k inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(CIC_ORDER); k++) integ[k] <= '0;
        end else if (in_valid) begin
            integ[0] <= integ[0] + step;
            for (int k = 1; k < int'(CIC_ORDER); k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt    <= '0;
            dec_strobe <= 1'b0;
        end else begin
            dec_strobe <= in_valid && (dec_cnt == CNT_LAST);
            if (in_valid) begin
                dec_cnt <= (dec_cnt == CNT_LAST) ? '0 : dec_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Sample the value left by the strobe-firing input, independent of later acceptances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp     <= '0;
            samp_vld <= 1'b0;
        end else begin
            samp_vld <= dec_strobe;
            if (dec_strobe) samp <= integ[CIC_ORDER-1];
        end
    end

    assign comb[0] = samp;

    for (genvar g = 0; g < int'(CIC_ORDER); g++) begin : g_comb
        cic_comb #(
            .WIDTH      (ACC_WIDTH),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_comb (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (samp_vld),
            .x      (comb[g]),
            .diff_c (comb[g+1])
        );
    end

    // One guard bit keeps the rounding add from wrapping before saturation
    assign biased       = (ACC_WIDTH+1)'(comb[CIC_ORDER]) + ROUND_BIAS;
    assign shifted_full = biased >>> SHIFT;
    assign shifted      = shifted_full[OUT_WIDTH:0];

    always_comb begin
        scaled = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_HI) begin
            scaled = SAT_HI[OUT_WIDTH-1:0];
        end else if (shifted < SAT_LO) begin
            scaled = SAT_LO[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= samp_vld;
            if (samp_vld) data_out <= scaled;
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator at default parameters with an independent bit-true model.
module tb_cic_decimator;

    localparam int R = 64;

    logic                clk;
    logic                rst_n;
    logic                data_in;
    logic                in_valid;
    logic signed [23:0]  data_out;
    logic                out_valid;

    cic_decimator #(
        .CIC_ORDER  (5),
        .DEC_RATE   (64),
        .DIFF_DELAY (1),
        .OUT_WIDTH  (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       n_checks = 0;
    int       n_bad    = 0;
    logic [2:0] vpipe;
    longint   exp_q[$];
    longint   last_out;
    int       n_out;
    int       dut_pulses;
    bit       dir_en;
    longint   dir_val;
    bit       per_en;
    longint   last_cyc;

    // Model: plain integrator cascade fed through an (N-1)-deep input delay
    longint mi  [5];
    longint mdl [4];
    int     mc  [5];
    int     mcnt;

    function automatic void model_reset();
        for (int k = 0; k < 5; k++) begin mi[k] = 0; mc[k] = 0; end
        for (int k = 0; k < 4; k++) mdl[k] = 0;
        mcnt = 0;
    endfunction

    function automatic void model_push(input bit b, output bit fire, output longint y);
        longint xd;
        longint w;
        longint lo32;
        int v;
        int t;
        fire = 1'b0;
        y    = 0;
        xd = mdl[3];
        for (int k = 3; k > 0; k--) mdl[k] = mdl[k-1];
        mdl[0] = b ? 64'sd1 : -64'sd1;
        mi[0] = mi[0] + xd;
        for (int k = 1; k < 5; k++) mi[k] = mi[k] + mi[k-1];
        mcnt++;
        if (mcnt == R) begin
            mcnt = 0;
            fire = 1'b1;
            lo32 = mi[4];
            v = int'(lo32[31:0]);
            for (int k = 0; k < 5; k++) begin
                t = v - mc[k];
                mc[k] = v;
                v = t;
            end
            w = longint'(v);
`ifdef CIC_ROUND_EN
            w = w + 128;
`endif
            w = w >>> 8;
            if (w > 8388607) w = 8388607;
            if (w < -8388608) w = -8388608;
            y = w;
        end
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // One cycle: check outputs settled from earlier edges, then present the next input
    task automatic step(input bit v, input bit b);
        bit     fire;
        longint y;
        longint e;
        @(negedge clk);
        check("out_valid", longint'(out_valid), longint'(vpipe[2]));
        if (out_valid) dut_pulses++;
        if (vpipe[2]) begin
            e = 0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("data", data_out, e);
            last_out = e;
            n_out++;
            if (dir_en && n_out >= 8) check("steady", data_out, dir_val);
            if (per_en && n_out > 1) check("period", cyc - last_cyc, 64);
            last_cyc = cyc;
        end else begin
            check("hold", data_out, last_out);
        end
        fire = 1'b0;
        y = 0;
        in_valid = v;
        data_in  = b;
        if (v) begin
            model_push(b, fire, y);
            if (fire) exp_q.push_back(y);
        end
        vpipe = {vpipe[1:0], fire};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = 1'b0;
        #1;
        check("rst_data", data_out, 0);
        check("rst_valid", longint'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        vpipe = '0;
        exp_q.delete();
        last_out   = 0;
        n_out      = 0;
        dut_pulses = 0;
    endtask

    // pat: 0 const 0, 1 const 1, 2 alternating 1,0, else random; gap_pct = % idle cycles
    task automatic run(input int n_acc, input int pat, input int gap_pct);
        int acc;
        bit v;
        bit b;
        acc = 0;
        while (acc < n_acc) begin
            v = ($urandom_range(99, 0) >= 32'(gap_pct));
            case (pat)
                0:       b = 1'b0;
                1:       b = 1'b1;
                2:       b = (acc % 2 == 0);
                default: b = 1'($urandom_range(1, 0));
            endcase
            step(v, b);
            if (v) acc++;
        end
    endtask

    task automatic flush();
        repeat (4) step(1'b0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = 1'b0;
        vpipe    = '0;
        last_out = 0;
        n_out    = 0;
        dut_pulses = 0;
        last_cyc = 0;
        dir_en   = 1'b0;
        dir_val  = 0;
        per_en   = 1'b0;
        model_reset();

        do_reset();
        dir_en = 1'b1; dir_val = 4194304; per_en = 1'b1;
        run(640, 1, 0);
        flush();
        check("pulses_one", dut_pulses, 10);

        do_reset();
        dir_val = -4194304;
        run(640, 0, 0);
        flush();
        check("pulses_zero", dut_pulses, 10);

        do_reset();
        dir_val = 0;
        run(640, 2, 0);
        flush();
        check("pulses_alt", dut_pulses, 10);

        do_reset();
        dir_val = 4194304; per_en = 1'b0;
        run(640, 1, 50);
        flush();
        check("pulses_gap", dut_pulses, 10);

        // Reset 30 inputs into a frame while data_out still holds the last sample
        run(30, 1, 50);
        do_reset();
        per_en = 1'b1;
        run(640, 1, 0);
        flush();
        check("pulses_rst", dut_pulses, 10);

        do_reset();
        dir_en = 1'b0;
        run(65536, 3, 0);
        flush();
        check("pulses_rand", dut_pulses, 1024);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
